bounce_gen: RTL

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bounce_gen.sv
// Mechanical-contact bounce emulator: on a level-change request it chatters the
// output at pseudo-random intervals for a fixed window, then holds the new level.
module bounce_gen #(
    parameter int          LGWAIT = 12,
    parameter int          LGGAP  = 4,
    parameter logic [15:0] SEED   = 16'hace1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_stb,
    input  logic i_level,
    output logic o_busy,
    output logic o_bounce
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } state_t;

    // NOTE: declaration initialisers give power-up values equal to the reset
    // values, so the block behaves the same before its first reset pulse.
    state_t              r_state  = S_IDLE;
    logic                r_level  = 1'b0;
    logic                r_bounce = 1'b0;
    logic                r_busy   = 1'b0;
    logic [LGWAIT-1:0]   r_window = '0;
    logic [LGGAP-1:0]    r_gap    = '0;
    logic [LGGAP-1:0]    r_settle = '0;
    logic [15:0]         r_lfsr   = SEED;

    state_t              w_state_next;
    logic                w_level_next;
    logic                w_bounce_next;
    logic [LGWAIT-1:0]   w_window_next;
    logic [LGGAP-1:0]    w_gap_next;
    logic [LGGAP-1:0]    w_settle_next;
    logic                w_lfsr_fb;
    logic                w_accept;

    // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_accept  = i_stb && (r_state == S_IDLE) && (i_level != r_level);

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        w_state_next  = r_state;
        w_level_next  = r_level;
        w_bounce_next = r_bounce;
        w_window_next = r_window;
        w_gap_next    = r_gap;
        w_settle_next = r_settle;

        case (r_state)
            S_IDLE: begin
                w_bounce_next = r_level;
                if (w_accept) begin
                    w_level_next  = i_level;
                    w_bounce_next = i_level;
                    w_window_next = '1;
                    w_gap_next    = r_lfsr[LGGAP-1:0];
                    w_state_next  = S_BOUNCE;
                end
            end
            S_BOUNCE: begin
                // Window expiry wins over a toggle due on the same cycle.
                if (r_window == '0) begin
                    w_bounce_next = r_level;
                    w_settle_next = '1;
                    w_state_next  = S_SETTLE;
                end else begin
                    w_window_next = r_window - 1'b1;
                    if (r_gap == '0) begin
                        w_bounce_next = ~r_bounce;
                        w_gap_next    = r_lfsr[LGGAP-1:0];
                    end else begin
                        w_gap_next = r_gap - 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                w_bounce_next = r_level;
                if (r_settle == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_settle_next = r_settle - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_level  <= 1'b0;
            r_bounce <= 1'b0;
            r_busy   <= 1'b0;
            r_window <= '0;
            r_gap    <= '0;
            r_settle <= '0;
            r_lfsr   <= SEED;
        end else begin
            r_state  <= w_state_next;
            r_level  <= w_level_next;
            r_bounce <= w_bounce_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_window <= w_window_next;
            r_gap    <= w_gap_next;
            r_settle <= w_settle_next;
            r_lfsr   <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign o_busy   = r_busy;
    assign o_bounce = r_bounce;

endmodule
